// File: rtl/poly_job_scheduler.sv
// poly_job_scheduler
//   Round-robin front end that shares one polynomial datapath between two
//   requesters. A granted job's operands are loaded into the datapath, then
//   y = A*x^2 + B*x + C is sequenced on the shared ALU. The result is
//   returned tagged with the id of the requester that owns the job.
//   Optional feature macro: POLY_SCHED_JOBCNT_EN adds the jobs_done counter.
module poly_job_scheduler #(
   parameter int DW      = 8,
   parameter int RR_INIT = 0
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            req0,
   input  logic            req1,
   input  logic [4*DW-1:0] req0_data,
   input  logic [4*DW-1:0] req1_data,
   output logic            ack0,
   output logic            ack1,
   output logic            done,
   output logic [DW-1:0]   result,
   output logic            result_id,
   output logic            busy,
   output logic            ld_a,
   output logic            ld_b,
   output logic            ld_c,
   output logic            ld_x,
   output logic            ld_r,
   output logic            ld_alu_out,
   output logic [1:0]      alu_select_a,
   output logic [1:0]      alu_select_b,
   output logic            alu_op,
   output logic [DW-1:0]   data_in,
   input  logic [DW-1:0]   dp_result
`ifdef POLY_SCHED_JOBCNT_EN
   ,
   output logic [7:0]      jobs_done
`endif
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_LD_A = 4'd1,
      S_LD_B = 4'd2,
      S_LD_C = 4'd3,
      S_LD_X = 4'd4,
      S_CYC0 = 4'd5,
      S_CYC1 = 4'd6,
      S_CYC2 = 4'd7,
      S_CYC3 = 4'd8,
      S_CYC4 = 4'd9,
      S_RESP = 4'd10
   } state_t;

   localparam logic RR_INIT_BIT = (RR_INIT != 0) ? 1'b1 : 1'b0;

   state_t            state_r;
   state_t            state_nxt_s;
   logic              prio_r;      // requester that wins a tie
   logic              owner_r;     // requester owning the job in flight
   logic [4*DW-1:0]   ops_r;       // {A,B,C,X} captured at grant
   logic [DW-1:0]     result_r;
   logic              result_id_r;
   logic              any_req_s;
   logic              win_s;
   logic              grant_s;

   // Arbitration: ack is suppressed while resetn is low so reset forces all outputs to 0.
   assign any_req_s = resetn & (req0 | req1);
   assign win_s     = (req0 & req1) ? prio_r : req1;
   assign grant_s   = (state_r == S_IDLE) & any_req_s;

   // Next-state and Moore control decode; ack is the only output that looks at the requests.
   always_comb begin
      state_nxt_s  = state_r;
      ack0         = 1'b0;
      ack1         = 1'b0;
      done         = 1'b0;
      busy         = 1'b1;
      ld_a         = 1'b0;
      ld_b         = 1'b0;
      ld_c         = 1'b0;
      ld_x         = 1'b0;
      ld_r         = 1'b0;
      ld_alu_out   = 1'b0;
      alu_select_a = 2'd0;
      alu_select_b = 2'd0;
      alu_op       = 1'b0;
      data_in      = {DW{1'b0}};
      case (state_r)
         S_IDLE: begin
            busy = 1'b0;
            if (grant_s) begin
               ack0        = ~win_s;
               ack1        = win_s;
               state_nxt_s = S_LD_A;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_LD_A: begin
            ld_a        = 1'b1;
            data_in     = ops_r[4*DW-1:3*DW];
            state_nxt_s = S_LD_B;
         end
         S_LD_B: begin
            ld_b        = 1'b1;
            data_in     = ops_r[3*DW-1:2*DW];
            state_nxt_s = S_LD_C;
         end
         S_LD_C: begin
            ld_c        = 1'b1;
            data_in     = ops_r[2*DW-1:DW];
            state_nxt_s = S_LD_X;
         end
         S_LD_X: begin
            ld_x        = 1'b1;
            data_in     = ops_r[DW-1:0];
            state_nxt_s = S_CYC0;
         end
         S_CYC0, S_CYC1: begin
            // a <= a*x, twice, gives A*x^2
            ld_a         = 1'b1;
            ld_alu_out   = 1'b1;
            alu_select_a = 2'd0;
            alu_select_b = 2'd3;
            alu_op       = 1'b1;
            state_nxt_s  = (state_r == S_CYC0) ? S_CYC1 : S_CYC2;
         end
         S_CYC2: begin
            // b <= b*x
            ld_b         = 1'b1;
            ld_alu_out   = 1'b1;
            alu_select_a = 2'd1;
            alu_select_b = 2'd3;
            alu_op       = 1'b1;
            state_nxt_s  = S_CYC3;
         end
         S_CYC3: begin
            // a <= a+b
            ld_a         = 1'b1;
            ld_alu_out   = 1'b1;
            alu_select_a = 2'd0;
            alu_select_b = 2'd1;
            state_nxt_s  = S_CYC4;
         end
         S_CYC4: begin
            // r <= a+c (a is also overwritten, harmless)
            ld_r         = 1'b1;
            ld_a         = 1'b1;
            ld_alu_out   = 1'b1;
            alu_select_a = 2'd0;
            alu_select_b = 2'd2;
            state_nxt_s  = S_RESP;
         end
         S_RESP: begin
            done        = 1'b1;
            state_nxt_s = S_IDLE;
         end
         default: begin
            busy        = 1'b0;
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Result bypass: the datapath value is visible in the same cycle done is high.
   always_comb begin
      result    = result_r;
      result_id = result_id_r;
      if (state_r == S_RESP) begin
         result    = dp_result;
         result_id = owner_r;
      end else begin
         result    = result_r;
         result_id = result_id_r;
      end
   end

   // State register, tie priority and operand capture at grant.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= S_IDLE;
         prio_r  <= RR_INIT_BIT;
         owner_r <= 1'b0;
         ops_r   <= {(4*DW){1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (grant_s) begin
            prio_r  <= ~win_s;
            owner_r <= win_s;
            ops_r   <= win_s ? req1_data : req0_data;
         end else begin
            prio_r  <= prio_r;
            owner_r <= owner_r;
            ops_r   <= ops_r;
         end
      end
   end

   // Held copy of the last returned result and its requester id.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         result_r    <= {DW{1'b0}};
         result_id_r <= 1'b0;
      end else if (state_r == S_RESP) begin
         result_r    <= dp_result;
         result_id_r <= owner_r;
      end else begin
         result_r    <= result_r;
         result_id_r <= result_id_r;
      end
   end

`ifdef POLY_SCHED_JOBCNT_EN
   logic [7:0] jobs_cnt_r;

   // Completed-job counter, wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         jobs_cnt_r <= 8'd0;
      end else if (state_r == S_RESP) begin
         jobs_cnt_r <= jobs_cnt_r + 8'd1;
      end else begin
         jobs_cnt_r <= jobs_cnt_r;
      end
   end

   assign jobs_done = jobs_cnt_r;
`endif

endmodule
